// File: rtl/serial_tx_pkg.sv
// -----------------------------------------------------------------------------
// serial_tx_pkg
// Shared types and width helpers for the serial pattern transmitter.
//   state_t    : transmitter FSM state (IDLE, SHIFT, GAP)
//   cnt_width  : counter width for a modulo-m counter, never narrower than 1
// -----------------------------------------------------------------------------
package serial_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    // A modulo-1 counter still needs one physical bit to exist.
    function automatic int cnt_width(input int modulus);
        return (modulus > 1) ? $clog2(modulus) : 1;
    endfunction

endpackage

// File: rtl/serial_tx_timer.sv
// -----------------------------------------------------------------------------
// serial_tx_timer
// Modulo-MODULUS up-counter with synchronous clear and count enable.
//   clk      in  clock
//   reset_n  in  asynchronous active-low reset
//   clear    in  force the count to 0 on the next edge (wins over en)
//   en       in  advance the count; wraps to 0 after MODULUS-1
//   tc       out terminal count: count == MODULUS-1
// -----------------------------------------------------------------------------
module serial_tx_timer
    import serial_tx_pkg::*;
#(
    parameter int MODULUS = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic en,
    output logic tc
);

    localparam int W = cnt_width(MODULUS);

    logic [W-1:0] count;

    assign tc = (count == W'(MODULUS - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en) begin
            count <= tc ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/serial_tx.sv
// -----------------------------------------------------------------------------
// serial_tx
// Serial pattern transmitter. Accepts an N-bit word over valid/ready and sends
// it LSB first on 'out', each bit held HOLD cycles, followed by GAP cycles of
// forced-low line, then a one-cycle 'done' pulse back in IDLE.
//   clk         in  clock, all state on posedge
//   reset_n     in  asynchronous active-low reset
//   load_valid  in  producer has a word on load_data
//   load_ready  out transmitter can accept a word (IDLE only)
//   load_data   in  word to send, bit 0 first
//   out         out serial line
//   busy        out frame in progress (SHIFT or GAP)
//   done        out one-cycle pulse at frame completion
// -----------------------------------------------------------------------------
module serial_tx #(
    parameter int N    = 64,
    parameter int HOLD = 2,
    parameter int GAP  = 64
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load_valid,
    output logic         load_ready,
    input  logic [N-1:0] load_data,
    output logic         out,
    output logic         busy,
    output logic         done
);

    import serial_tx_pkg::*;

    // The parameter GAP hides the package state literal of the same name, so
    // that state is always written fully qualified in this module.
    localparam int BIT_W = $clog2(N);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(N - 1);

    state_t           state;
    logic [N-1:0]     shreg;
    logic [BIT_W-1:0] bit_cnt;
    logic             hold_tc;
    logic             gap_tc;

    // Timers sit at 0 outside their own state, so every state entry starts
    // them from a clean count.
    serial_tx_timer #(.MODULUS(HOLD)) hold_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (state != SHIFT),
        .en      (state == SHIFT),
        .tc      (hold_tc)
    );

    serial_tx_timer #(.MODULUS(GAP)) gap_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (state != serial_tx_pkg::GAP),
        .en      (state == serial_tx_pkg::GAP),
        .tc      (gap_tc)
    );

    // 'out' is registered alongside shreg: on each bit boundary it is loaded
    // with the bit about to become shreg[0], so it always equals shreg[0]
    // while in SHIFT and 0 everywhere else.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: shreg is a plain register, not a memory array, so it is
            // reset with everything else; a reset frame leaves no stale bits.
            state      <= IDLE;
            shreg      <= '0;
            bit_cnt    <= '0;
            out        <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            load_ready <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch sees
            // the pre-edge values of state, shreg and bit_cnt.
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_valid && load_ready) begin
                        state      <= SHIFT;
                        shreg      <= load_data;
                        bit_cnt    <= '0;
                        out        <= load_data[0];
                        busy       <= 1'b1;
                        load_ready <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (hold_tc) begin
                        shreg <= shreg >> 1;
                        if (bit_cnt == BIT_LAST) begin
                            state   <= serial_tx_pkg::GAP;
                            bit_cnt <= '0;
                            out     <= 1'b0;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            out     <= shreg[1];
                        end
                    end
                end
                serial_tx_pkg::GAP: begin
                    if (gap_tc) begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        load_ready <= 1'b1;
                        done       <= 1'b1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    shreg      <= '0;
                    bit_cnt    <= '0;
                    out        <= 1'b0;
                    busy       <= 1'b0;
                    load_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/serial_tx.md
# serial_tx

Serial pattern transmitter: accepts an N-bit word over a valid/ready handshake and drives it onto a single output line, LSB first. Each bit is held for HOLD clock cycles, then the line is held low for GAP cycles. It is the transmit end of the board's single-wire pattern link. It feeds the existing N-stage shift-register detector, which flags `on` when two consecutive sampled bits are high. HOLD ≥ 2 therefore makes every transmitted 1 detectable by that receiver, and GAP ≥ N flushes it between frames.

## Interface
- N, 64: word width in bits, N ≥ 2.
- HOLD, 2: cycles each bit is driven, HOLD ≥ 1.
- GAP, 64: cycles of forced-low line after the last bit, GAP ≥ 1.

- clk  in  1  single clock, all state on posedge.
- reset_n  in  1  reset, asynchronous, active-low.
- load_valid  in  1  producer has a word on load_data.
- load_ready  out  1  transmitter can accept a word.
- load_data  in  N  word to send; bit 0 is sent first.
- out  out  1  serial line.
- busy  out  1  frame in progress (SHIFT or GAP).
- done  out  1  one-cycle pulse at frame completion.

## Operation
- FSM states and transitions:
  - IDLE: out=0, load_ready=1, busy=0. Goes to SHIFT on load_valid && load_ready.
  - SHIFT: out=shreg[0], which holds each bit for HOLD cycles. After the last cycle of bit N-1, goes to GAP.
  - GAP: out=0 for GAP cycles, then goes to IDLE with done=1.
- Handshake:
  - Transfer occurs on a rising edge with load_valid && load_ready. load_data is captured into shreg[N-1:0] on that edge only.
  - load_ready is 0 in SHIFT and GAP.
  - While load_ready=0, load_valid and load_data are ignored; no queuing.
- Counters:
  - hold_cnt runs 0..HOLD-1 within each bit; shreg shifts right one place when hold_cnt wraps.
  - bit_cnt is $clog2(N) bits wide and runs 0..N-1. SHIFT exits when bit_cnt==N-1 and hold_cnt==HOLD-1.
  - gap_cnt runs 0..GAP-1.
  - All counters clear on every state entry and never wrap beyond their terminal value.
- Back-to-back frames: done coincides with IDLE and load_ready=1, so a word offered in the done cycle is accepted on that edge.
- Reset:
  - Reset mid-frame immediately forces IDLE, out=0, busy=0, done=0, load_ready=1, and shreg and counters to 0. The partial frame is discarded and never resumed.

## Timing
- Reset values: out=0, load_ready=1, busy=0, done=0.
- All outputs are registered or decoded from registered state; there is no combinational path from load_valid to any output except through state.
- Frame timeline, with handshake edge t0 and cycle k meaning the k-th cycle after t0:
  - Cycles 1..N·HOLD: bit (k-1)/HOLD on out, busy=1.
  - Cycles N·HOLD+1..N·HOLD+GAP: out=0, busy=1.
  - Cycle N·HOLD+GAP+1: done=1, busy=0, load_ready=1.
- Frame period, back-to-back: N·HOLD+GAP+1 cycles.

## Structure
- Shared package serial_tx_pkg:
  - state typedef: enum logic [1:0] {IDLE, SHIFT, GAP}.
  - Width helper constants for the counters, derived with $clog2.
- Sub-module serial_tx_timer:
  - Parameterised modulo counter with clear, enable, and terminal-count output.
  - Instantiated twice: as hold_cnt and as gap_cnt.
- Top level contains the FSM, shreg and bit_cnt.

## Test plan
All scenarios use N=8, HOLD=2, GAP=4 unless stated.
- Reset: assert reset_n=0 asynchronously mid-cycle, then release → out=0, load_ready=1, busy=0, done=0 throughout and after.
- Single frame, load 8'hA5 at t0 → out over cycles 1–16 is 1,1,0,0,1,1,0,0,0,0,1,1,0,0,1,1. Cycles 17–20 are 0. done=1 only in cycle 21. busy=1 in cycles 1–20.
- Busy ignore: hold load_valid=1 with 8'h3C from cycle 3 while 8'hA5 is sending → 8'h3C accepted only at the cycle-21 edge. Its first bit, 0, appears in cycle 22. The 8'hA5 pattern is unchanged.
- Reset mid-frame: drop reset_n during cycle 7 of an 8'hFF frame → out falls to 0 without waiting for an edge, and load_ready=1. The next load of 8'h01 gives out=1 in cycles 1–2 only.
- Loopback: drive the shift-register detector (N=8) from out, load 8'h06 → detector `on` rises while bits 1 and 2 are in its stages. `on` is 0 again by the end of GAP with GAP=8.
- HOLD=1: load 8'h81 → out=1 in cycle 1, 0 in cycles 2–7, 1 in cycle 8, then GAP zeros, then done in cycle 13.
